// File: rtl/rfphoenix_tlb_sa.sv
// Set-associative TLB with per-set true-LRU, round-robin or explicit replacement,
// ASID-selective/global flush and a dirty-victim writeback handshake.
module rfphoenix_tlb_sa #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int VAW    = 32,
    parameter int PAW    = 32,
    parameter int PGBITS = 13,
    parameter int ASIDW  = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    output logic                     rdy_o,
    input  logic                     xlat_v_i,
    input  logic [VAW-1:0]           vadr_i,
    input  logic [ASIDW-1:0]         asid_i,
    input  logic                     we_i,
    output logic                     hit_o,
    output logic                     miss_o,
    output logic [VAW-1:0]           miss_adr_o,
    output logic [PAW-1:0]           padr_o,
    output logic [2:0]               rwx_o,
    input  logic [1:0]               al_i,
    input  logic                     wr_i,
    input  logic [$clog2(WAYS)-1:0]  wr_way_i,
    input  logic [VAW-PGBITS-1:0]    wr_vpn_i,
    input  logic [PAW-PGBITS-1:0]    wr_ppn_i,
    input  logic [ASIDW-1:0]         wr_asid_i,
    input  logic                     wr_g_i,
    input  logic [2:0]               wr_rwx_i,
    input  logic [PAW-1:0]           wr_pteadr_i,
    input  logic                     flush_i,
    input  logic                     flush_all_i,
    input  logic [ASIDW-1:0]         flush_asid_i,
    output logic                     evict_v_o,
    output logic [PAW-1:0]           evict_adr_o,
    output logic [PAW-PGBITS-1:0]    evict_ppn_o,
    input  logic                     evict_ack_i
);
    localparam int WAYW = $clog2(WAYS);
    localparam int SETW = $clog2(SETS);
    localparam int VPNW = VAW - PGBITS;
    localparam int PPNW = PAW - PGBITS;
    localparam int TAGW = VPNW - SETW;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH, ST_EVICT} state_e;
    typedef logic [WAYS-1:0][WAYW-1:0] ages_t;

    state_e                      state_q, state_d;
    logic [SETW-1:0]             cnt_q, cnt_d;
    logic [WAYW-1:0]             rr_q, rr_d;
    logic                        fl_all_q, fl_all_d;
    logic [ASIDW-1:0]            fl_asid_q, fl_asid_d;
    logic [WAYS-1:0]             v_q [SETS], v_d [SETS];
    logic [WAYS-1:0]             m_q [SETS], m_d [SETS];
    ages_t                       age_q [SETS], age_d [SETS];
    logic [WAYS-1:0]             g_q [SETS], g_d [SETS];
    logic [WAYS-1:0][TAGW-1:0]   tag_q [SETS], tag_d [SETS];
    logic [WAYS-1:0][ASIDW-1:0]  asid_q [SETS], asid_d [SETS];
    logic [WAYS-1:0][PPNW-1:0]   ppn_q [SETS], ppn_d [SETS];
    logic [WAYS-1:0][2:0]        rwx_q [SETS], rwx_d [SETS];
    logic [WAYS-1:0][PAW-1:0]    pte_q [SETS], pte_d [SETS];
    logic                        hit_q, hit_d, miss_q, miss_d;
    logic [VAW-1:0]              miss_adr_q, miss_adr_d;
    logic [PAW-1:0]              padr_q, padr_d;
    logic [2:0]                  rwxo_q, rwxo_d;
    logic [PAW-1:0]              evict_adr_q, evict_adr_d;
    logic [PPNW-1:0]             evict_ppn_q, evict_ppn_d;

    logic [SETW-1:0]  lk_set, wr_set;
    logic [TAGW-1:0]  lk_tag, wr_tag;
    logic [WAYS-1:0]  lk_match;
    logic             lk_hit, inv_found;
    logic [WAYW-1:0]  lk_way, inv_way, lru_way, vic_way;

    // Touched way becomes youngest; only ways younger than its old age shift down.
    function automatic ages_t lru_touch(input ages_t ages, input logic [WAYW-1:0] way,
                                        input logic [WAYW-1:0] old);
        lru_touch = ages;
        for (int w = 0; w < WAYS; w++)
            if (ages[w] < old) lru_touch[w] = ages[w] + WAYW'(1);
        lru_touch[way] = '0;
    endfunction

    assign lk_set = vadr_i[PGBITS +: SETW];
    assign lk_tag = vadr_i[PGBITS+SETW +: TAGW];
    assign wr_set = wr_vpn_i[SETW-1:0];
    assign wr_tag = wr_vpn_i[VPNW-1:SETW];

    always_comb begin
        lk_hit   = 1'b0;
        lk_way   = '0;
        lk_match = '0;
        for (int w = 0; w < WAYS; w++)
            lk_match[w] = v_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag) &&
                          ((asid_q[lk_set][w] == asid_i) || g_q[lk_set][w]);
        for (int w = WAYS-1; w >= 0; w--)
            if (lk_match[w]) begin
                lk_hit = 1'b1;
                lk_way = WAYW'(w);
            end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS-1; w >= 0; w--)
            if (!v_q[wr_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYW'(w);
            end
        lru_way = '0;
        for (int w = 1; w < WAYS; w++)
            if (age_q[wr_set][w] > age_q[wr_set][lru_way]) lru_way = WAYW'(w);
        if (inv_found)           vic_way = inv_way;
        else if (al_i == 2'b00)  vic_way = wr_way_i;
        else if (al_i == 2'b10)  vic_way = rr_q;
        else                     vic_way = lru_way;
    end

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  rr_d = rr_q;
        fl_all_d = fl_all_q;  fl_asid_d = fl_asid_q;
        evict_adr_d = evict_adr_q;  evict_ppn_d = evict_ppn_q;
        v_d = v_q;  m_d = m_q;  age_d = age_q;  g_d = g_q;  tag_d = tag_q;
        asid_d = asid_q;  ppn_d = ppn_q;  rwx_d = rwx_q;  pte_d = pte_q;
        case (state_q)
            ST_INIT: begin
                v_d[cnt_q]   = '0;
                m_d[cnt_q]   = '0;
                age_d[cnt_q] = '0;
                cnt_d = cnt_q + SETW'(1);
                if (cnt_q == SETW'(SETS-1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d   = ST_FLUSH;
                    cnt_d     = '0;
                    fl_all_d  = flush_all_i;
                    fl_asid_d = flush_asid_i;
                end else if (wr_i) begin
                    v_d[wr_set][vic_way]    = 1'b1;
                    m_d[wr_set][vic_way]    = 1'b0;
                    g_d[wr_set][vic_way]    = wr_g_i;
                    tag_d[wr_set][vic_way]  = wr_tag;
                    asid_d[wr_set][vic_way] = wr_asid_i;
                    ppn_d[wr_set][vic_way]  = wr_ppn_i;
                    rwx_d[wr_set][vic_way]  = wr_rwx_i;
                    pte_d[wr_set][vic_way]  = wr_pteadr_i;
                    // An invalid way counts as oldest so every valid way ages past it.
                    age_d[wr_set] = lru_touch(age_q[wr_set], vic_way,
                        v_q[wr_set][vic_way] ? age_q[wr_set][vic_way] : WAYW'(WAYS-1));
                    if (al_i == 2'b10) rr_d = rr_q + WAYW'(1);
                    if (v_q[wr_set][vic_way] && m_q[wr_set][vic_way]) begin
                        evict_adr_d = pte_q[wr_set][vic_way];
                        evict_ppn_d = ppn_q[wr_set][vic_way];
                        state_d     = ST_EVICT;
                    end
                end else if (xlat_v_i && lk_hit) begin
                    if (we_i) m_d[lk_set][lk_way] = 1'b1;
                    age_d[lk_set] = lru_touch(age_q[lk_set], lk_way, age_q[lk_set][lk_way]);
                end
            end
            ST_FLUSH: begin
                for (int w = 0; w < WAYS; w++)
                    if (fl_all_q || ((asid_q[cnt_q][w] == fl_asid_q) && !g_q[cnt_q][w]))
                        v_d[cnt_q][w] = 1'b0;
                cnt_d = cnt_q + SETW'(1);
                if (cnt_q == SETW'(SETS-1)) state_d = ST_RUN;
            end
            ST_EVICT: if (evict_ack_i) state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Lookup result registers; lookups read pre-write contents.
    always_comb begin
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        miss_adr_d = miss_adr_q;
        padr_d     = padr_q;
        rwxo_d     = '0;
        if (state_q == ST_RUN && xlat_v_i) begin
            if (lk_hit) begin
                hit_d  = 1'b1;
                padr_d = {ppn_q[lk_set][lk_way], vadr_i[PGBITS-1:0]};
                rwxo_d = rwx_q[lk_set][lk_way];
            end else begin
                miss_d     = 1'b1;
                miss_adr_d = vadr_i;
                padr_d     = PAW'(vadr_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_INIT;  cnt_q <= '0;  rr_q <= '0;
            fl_all_q <= 1'b0;  fl_asid_q <= '0;
            hit_q <= 1'b0;  miss_q <= 1'b0;  miss_adr_q <= '0;  padr_q <= '0;  rwxo_q <= '0;
            evict_adr_q <= '0;  evict_ppn_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                v_q[s]   <= '0;
                m_q[s]   <= '0;
                age_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  rr_q <= rr_d;
            fl_all_q <= fl_all_d;  fl_asid_q <= fl_asid_d;
            hit_q <= hit_d;  miss_q <= miss_d;  miss_adr_q <= miss_adr_d;
            padr_q <= padr_d;  rwxo_q <= rwxo_d;
            evict_adr_q <= evict_adr_d;  evict_ppn_q <= evict_ppn_d;
            v_q <= v_d;  m_q <= m_d;  age_q <= age_d;
        end
    end

    always_ff @(posedge clk_i) begin
        g_q <= g_d;  tag_q <= tag_d;  asid_q <= asid_d;
        ppn_q <= ppn_d;  rwx_q <= rwx_d;  pte_q <= pte_d;
    end

    assign rdy_o       = (state_q == ST_RUN);
    assign evict_v_o   = (state_q == ST_EVICT);
    assign hit_o       = hit_q;
    assign miss_o      = miss_q;
    assign miss_adr_o  = miss_adr_q;
    assign padr_o      = padr_q;
    assign rwx_o       = rwxo_q;
    assign evict_adr_o = evict_adr_q;
    assign evict_ppn_o = evict_ppn_q;
endmodule

// File: tb/tb_rfphoenix_tlb_sa.sv
// Scoreboard bench for rfphoenix_tlb_sa: directed scenarios plus randomized
// lookups/writes checked against a timestamp-based reference model.
module tb_rfphoenix_tlb_sa;
    localparam int WAYS = 4, SETS = 16, VAW = 32, PAW = 32, PGBITS = 13, ASIDW = 10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        rdy_o, xlat_v_i = 1'b0, we_i = 1'b0, hit_o, miss_o;
    logic [31:0] vadr_i = '0, miss_adr_o, padr_o, wr_pteadr_i = '0, evict_adr_o;
    logic [9:0]  asid_i = '0, wr_asid_i = '0, flush_asid_i = '0;
    logic [2:0]  rwx_o, wr_rwx_i = '0;
    logic [1:0]  al_i = '0, wr_way_i = '0;
    logic        wr_i = 1'b0, wr_g_i = 1'b0, flush_i = 1'b0, flush_all_i = 1'b0;
    logic [18:0] wr_vpn_i = '0, wr_ppn_i = '0, evict_ppn_o;
    logic        evict_v_o, evict_ack_i = 1'b0;

    rfphoenix_tlb_sa #(.WAYS(WAYS), .SETS(SETS), .VAW(VAW), .PAW(PAW),
                       .PGBITS(PGBITS), .ASIDW(ASIDW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_o(rdy_o), .xlat_v_i(xlat_v_i),
        .vadr_i(vadr_i), .asid_i(asid_i), .we_i(we_i), .hit_o(hit_o), .miss_o(miss_o),
        .miss_adr_o(miss_adr_o), .padr_o(padr_o), .rwx_o(rwx_o), .al_i(al_i),
        .wr_i(wr_i), .wr_way_i(wr_way_i), .wr_vpn_i(wr_vpn_i), .wr_ppn_i(wr_ppn_i),
        .wr_asid_i(wr_asid_i), .wr_g_i(wr_g_i), .wr_rwx_i(wr_rwx_i),
        .wr_pteadr_i(wr_pteadr_i), .flush_i(flush_i), .flush_all_i(flush_all_i),
        .flush_asid_i(flush_asid_i), .evict_v_o(evict_v_o), .evict_adr_o(evict_adr_o),
        .evict_ppn_o(evict_ppn_o), .evict_ack_i(evict_ack_i));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    typedef struct packed {
        logic        hit;
        logic [31:0] padr;
        logic [2:0]  rwx;
        logic [31:0] madr;
    } exp_t;
    exp_t expq[$];

    // Reference model: entries plus a last-use timestamp per way.
    bit          mv [SETS][WAYS];
    bit          mm [SETS][WAYS];
    bit          mg [SETS][WAYS];
    logic [18:0] mvpn [SETS][WAYS];
    logic [9:0]  masid [SETS][WAYS];
    logic [18:0] mppn [SETS][WAYS];
    logic [2:0]  mrwx [SETS][WAYS];
    logic [31:0] mpte [SETS][WAYS];
    longint      mts [SETS][WAYS];
    longint      tick = 0;
    int          rr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (!rdy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_o) chk("rdy_timeout", rdy_o, 1);
    endtask

    task automatic model_lookup(input logic [31:0] va, input logic [9:0] a, input logic st,
                                output exp_t e);
        int s, hw;
        s  = int'(va[16:13]);
        hw = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && mv[s][w] && mvpn[s][w] == va[31:13] && (masid[s][w] == a || mg[s][w]))
                hw = w;
        if (hw >= 0) begin
            e.hit = 1'b1; e.padr = {mppn[s][hw], va[12:0]}; e.rwx = mrwx[s][hw]; e.madr = '0;
            tick++;
            mts[s][hw] = tick;
            if (st) mm[s][hw] = 1'b1;
        end else begin
            e.hit = 1'b0; e.padr = va; e.rwx = '0; e.madr = va;
        end
    endtask

    task automatic lookup(input logic [31:0] va, input logic [9:0] a, input logic st);
        exp_t e;
        wait_rdy();
        xlat_v_i = 1'b1; vadr_i = va; asid_i = a; we_i = st;
        model_lookup(va, a, st, e);
        expq.push_back(e);
        @(negedge clk);
        xlat_v_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_write(input logic [18:0] vpn, input logic [18:0] ppn, input logic [9:0] a,
                            input logic g, input logic [2:0] rwx, input logic [31:0] pte,
                            input logic [1:0] mode, input logic [1:0] way);
        int s, vic, hold;
        bit ev;
        logic [31:0] opte;
        logic [18:0] oppn;
        longint best;
        wait_rdy();
        s = int'(vpn[3:0]);
        vic = -1;
        for (int w = 0; w < WAYS; w++) if (vic < 0 && !mv[s][w]) vic = w;
        if (vic < 0) begin
            if (mode == 2'b00) vic = int'(way);
            else if (mode == 2'b10) vic = rr;
            else begin
                vic = 0; best = mts[s][0];
                for (int w = 1; w < WAYS; w++) if (mts[s][w] < best) begin best = mts[s][w]; vic = w; end
            end
        end
        if (mode == 2'b10) rr = (rr + 1) % WAYS;
        ev = mv[s][vic] && mm[s][vic];
        opte = mpte[s][vic];
        oppn = mppn[s][vic];
        wr_i = 1'b1; wr_vpn_i = vpn; wr_ppn_i = ppn; wr_asid_i = a; wr_g_i = g;
        wr_rwx_i = rwx; wr_pteadr_i = pte; al_i = mode; wr_way_i = way;
        @(negedge clk);
        wr_i = 1'b0;
        mv[s][vic] = 1'b1; mm[s][vic] = 1'b0; mg[s][vic] = g; mvpn[s][vic] = vpn;
        masid[s][vic] = a; mppn[s][vic] = ppn; mrwx[s][vic] = rwx; mpte[s][vic] = pte;
        tick++;
        mts[s][vic] = tick;
        if (ev) begin
            chk("evict_v", evict_v_o, 1);
            chk("evict_adr", evict_adr_o, opte);
            chk("evict_ppn", evict_ppn_o, oppn);
            chk("evict_rdy_low", rdy_o, 0);
            hold = $urandom_range(1, 3);
            repeat (hold) begin
                @(negedge clk);
                chk("evict_v_held", evict_v_o, 1);
                chk("evict_rdy_held", rdy_o, 0);
            end
            evict_ack_i = 1'b1;
            @(negedge clk);
            evict_ack_i = 1'b0;
            chk("evict_v_drop", evict_v_o, 0);
            chk("evict_rdy_back", rdy_o, 1);
        end else begin
            chk("no_evict", evict_v_o, 0);
        end
    endtask

    task automatic do_flush(input logic all, input logic [9:0] a);
        int n;
        wait_rdy();
        flush_i = 1'b1; flush_all_i = all; flush_asid_i = a;
        @(negedge clk);
        flush_i = 1'b0; flush_all_i = !all; flush_asid_i = a + 10'd1;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (all || (masid[s][w] == a && !mg[s][w])) mv[s][w] = 1'b0;
        n = 0;
        while (!rdy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("flush_rdy_low_cycles", n, SETS);
        flush_all_i = 1'b0; flush_asid_i = '0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && (hit_o || miss_o)) begin
            if (expq.size() == 0) chk("unexpected_result", {hit_o, miss_o}, 0);
            else begin
                e = expq.pop_front();
                chk("hit", hit_o, e.hit);
                chk("miss", miss_o, !e.hit);
                chk("padr", padr_o, e.padr);
                chk("rwx", rwx_o, e.rwx);
                if (!e.hit) chk("miss_adr", miss_adr_o, e.madr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [18:0] vpn;
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy_o, 0);
        chk("rst_hit", hit_o, 0);
        chk("rst_miss", miss_o, 0);
        chk("rst_miss_adr", miss_adr_o, 0);
        chk("rst_padr", padr_o, 0);
        chk("rst_rwx", rwx_o, 0);
        chk("rst_evict_v", evict_v_o, 0);
        chk("rst_evict_adr", evict_adr_o, 0);
        chk("rst_evict_ppn", evict_ppn_o, 0);
        rst_n = 1'b1;
        n = 0;
        while (!rdy_o && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("init_rdy_low_cycles", n, SETS);

        lookup(32'h0000_2000, 10'd0, 1'b0);

        // Basic translation and ASID mismatch.
        do_write(19'h1, 19'h7F, 10'd3, 1'b0, 3'd5, 32'h1000_0000, 2'b01, 2'd0);
        lookup(32'h0000_3ABC, 10'd3, 1'b0);
        lookup(32'h0000_3ABC, 10'd4, 1'b0);

        // LRU in set 1: fill, touch ways 0..2, fifth write replaces way 3.
        do_write(19'h11, 19'h111, 10'd3, 1'b0, 3'd1, 32'h1000_0010, 2'b01, 2'd0);
        do_write(19'h21, 19'h121, 10'd3, 1'b0, 3'd2, 32'h1000_0020, 2'b01, 2'd0);
        do_write(19'h31, 19'h131, 10'd3, 1'b0, 3'd3, 32'h1000_0030, 2'b01, 2'd0);
        lookup({19'h01, 13'h0}, 10'd3, 1'b0);
        lookup({19'h11, 13'h0}, 10'd3, 1'b0);
        lookup({19'h21, 13'h0}, 10'd3, 1'b0);
        do_write(19'h41, 19'h141, 10'd3, 1'b0, 3'd4, 32'h1000_0040, 2'b01, 2'd0);
        for (int i = 0; i < 5; i++) lookup({19'(i * 16 + 1), 13'h123}, 10'd3, 1'b0);

        // Store hit marks dirty; explicit-way replacement evicts it.
        for (int i = 0; i < 4; i++)
            do_write(19'(i * 16 + 2), 19'(32'h200 + i), 10'd1, 1'b0, 3'd7, 32'h2000_0000 + i * 4, 2'b00, 2'd0);
        lookup({19'h12, 13'h44}, 10'd1, 1'b1);
        do_write(19'h42, 19'h242, 10'd1, 1'b0, 3'd6, 32'h2000_0100, 2'b00, 2'd1);
        lookup({19'h12, 13'h44}, 10'd1, 1'b0);
        lookup({19'h42, 13'h44}, 10'd1, 1'b0);

        // Round-robin in set 3.
        for (int i = 0; i < 4; i++)
            do_write(19'(i * 16 + 3), 19'(32'h300 + i), 10'd2, 1'b0, 3'd1, 32'h3000_0000 + i * 4, 2'b00, 2'd0);
        for (int i = 4; i < 10; i++) begin
            do_write(19'(i * 16 + 3), 19'(32'h300 + i), 10'd2, 1'b0, 3'd2, 32'h3000_0000 + i * 4, 2'b10, 2'd0);
            for (int j = 0; j <= i; j++) lookup({19'(j * 16 + 3), 13'h7}, 10'd2, 1'b0);
        end

        // Randomized mix over sets 0..3.
        for (int i = 0; i < 300; i++) begin
            vpn = (19'($urandom_range(0, 7)) << 4) | 19'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 70)
                lookup({vpn, 13'($urandom)}, 10'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            else
                do_write(vpn, 19'($urandom), 10'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                         3'($urandom), $urandom, 2'($urandom), 2'($urandom));
        end

        // ASID-selective flush keeps global entries, then a global flush.
        do_write(19'h05, 19'h505, 10'd3, 1'b1, 3'd5, 32'h5000_0000, 2'b01, 2'd0);
        do_write(19'h15, 19'h515, 10'd3, 1'b0, 3'd6, 32'h5000_0004, 2'b01, 2'd0);
        do_flush(1'b0, 10'd3);
        lookup({19'h05, 13'h1}, 10'd3, 1'b0);
        lookup({19'h15, 13'h1}, 10'd3, 1'b0);
        for (int i = 0; i < 40; i++) begin
            vpn = (19'($urandom_range(0, 7)) << 4) | 19'($urandom_range(0, 3));
            lookup({vpn, 13'($urandom)}, 10'($urandom_range(0, 3)), 1'b0);
        end
        do_flush(1'b1, 10'd0);
        lookup({19'h05, 13'h1}, 10'd3, 1'b0);
        lookup({19'h21, 13'h1}, 10'd3, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
